// File: rtl/tile_layer_gen.sv
// Scrolling, flippable tilemap layer: per-pixel output from a double-buffered
// cell fetch, with the code/attr RAM port shared between the fetch and the CPU.
module tile_layer_gen #(
    parameter int unsigned PLANES    = 2,
    parameter int unsigned COLS_LOG2 = 6,
    parameter int unsigned ROWS_LOG2 = 5,
    parameter int unsigned CODE_W    = 10,
    parameter int unsigned COLOR_W   = 6
) (
    input  logic                           master_clk,
    input  logic                           reset,
    input  logic                           pix_ce,
    input  logic [8:0]                     hpix,
    input  logic [7:0]                     vpix,
    input  logic                           flip,
    input  logic [COLS_LOG2+2:0]           scroll_x,
    input  logic [ROWS_LOG2+2:0]           scroll_y,
    input  logic [COLS_LOG2+ROWS_LOG2-1:0] cpu_addr,
    input  logic [7:0]                     cpu_din,
    input  logic                           cpu_cs_code,
    input  logic                           cpu_cs_attr,
    input  logic                           cpu_rd,
    input  logic                           cpu_wr,
    output logic [7:0]                     cpu_dout,
    output logic                           cpu_wait,
    output logic [CODE_W+2:0]              rom_addr,
    input  logic [PLANES*8-1:0]            rom_data,
    output logic [COLOR_W+PLANES-1:0]      pixel_out,
    output logic                           transparent
);
    localparam int unsigned XW = COLS_LOG2 + 3;
    localparam int unsigned YW = ROWS_LOG2 + 3;
    localparam int unsigned AW = COLS_LOG2 + ROWS_LOG2;
    localparam int unsigned DW = PLANES * 8;

    typedef enum logic [2:0] {StIdle, StRamRd, StRomAdr, StRomLat, StCpuAcc} state_e;

    state_e               state_q;
    logic                 fetch_req_q;
    logic [AW-1:0]        faddr_q;
    logic [2:0]           frow_q;
    logic [COLOR_W-1:0]   fcolor_q;
    logic [DW-1:0]        pend_data_q, act_data_q;
    logic [COLOR_W-1:0]   pend_color_q, act_color_q;
    logic                 cpu_done_q;

    logic [7:0] code_ram [2**AW];
    logic [7:0] attr_ram [2**AW];

    logic [8:0]           h_eff;
    logic [7:0]           v_eff;
    logic [XW-1:0]        ex;
    logic [YW-1:0]        ey;
    logic [COLS_LOG2-1:0] fcol;
    logic [AW-1:0]        fetch_addr;
    logic                 entry, trigger;
    logic                 cpu_req, cpu_pend;
    logic [AW-1:0]        ram_addr;
    logic [7:0]           code_rd, attr_rd;
    logic [CODE_W-1:0]    tile_code;
    logic [DW-1:0]        src_data;
    logic [COLOR_W-1:0]   src_color;
    logic [2:0]           bit_sel;
    logic [7:0]           plane_byte;
    logic [PLANES-1:0]    planes;

    assign h_eff = flip ? ~hpix : hpix;
    assign v_eff = flip ? ~vpix : vpix;
    assign ex    = XW'(h_eff) + scroll_x;
    assign ey    = YW'(v_eff) + scroll_y;

    // Entering a cell fetches the neighbour we will scan into next.
    assign entry      = flip ? (ex[2:0] == 3'd7) : (ex[2:0] == 3'd0);
    assign trigger    = pix_ce & entry;
    assign fcol       = flip ? ex[XW-1:3] - COLS_LOG2'(1) : ex[XW-1:3] + COLS_LOG2'(1);
    assign fetch_addr = {ey[YW-1:3], fcol};

    assign cpu_req  = (cpu_rd | cpu_wr) & (cpu_cs_code | cpu_cs_attr);
    assign cpu_pend = cpu_req & ~cpu_done_q;

    assign ram_addr  = (state_q == StCpuAcc) ? cpu_addr : faddr_q;
    assign code_rd   = code_ram[ram_addr];
    assign attr_rd   = attr_ram[ram_addr];
    assign tile_code = CODE_W'({attr_rd, code_rd});

    // At cell entry the pending buffer already holds the cell being entered.
    always_comb begin
        src_data   = entry ? pend_data_q : act_data_q;
        src_color  = entry ? pend_color_q : act_color_q;
        bit_sel    = ~ex[2:0];
        plane_byte = '0;
        planes     = '0;
        for (int p = 0; p < int'(PLANES); p++) begin
            plane_byte = src_data[8*p +: 8];
            planes[p]  = plane_byte[bit_sel];
        end
    end

    always_ff @(posedge master_clk) begin
        if (!reset && state_q == StCpuAcc && cpu_wr) begin
            if (cpu_cs_code) begin
                code_ram[ram_addr] <= cpu_din;
            end else if (cpu_cs_attr) begin
                attr_ram[ram_addr] <= cpu_din;
            end
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            state_q      <= StIdle;
            fetch_req_q  <= 1'b0;
            faddr_q      <= '0;
            frow_q       <= '0;
            fcolor_q     <= '0;
            pend_data_q  <= '0;
            pend_color_q <= '0;
            act_data_q   <= '0;
            act_color_q  <= '0;
            rom_addr     <= '0;
            pixel_out    <= '0;
            transparent  <= 1'b1;
            cpu_wait     <= 1'b0;
            cpu_dout     <= '0;
            // A strobe held across reset must be dropped and reissued.
            cpu_done_q   <= 1'b1;
        end else begin
            if (trigger) begin
                faddr_q <= fetch_addr;
                frow_q  <= ey[2:0];
            end
            if (trigger && state_q != StIdle) begin
                fetch_req_q <= 1'b1;
            end

            if (pix_ce) begin
                pixel_out   <= {src_color, planes};
                transparent <= (planes == '0);
                if (entry) begin
                    act_data_q  <= pend_data_q;
                    act_color_q <= pend_color_q;
                end
            end

            if (state_q == StCpuAcc) begin
                cpu_wait   <= 1'b0;
                cpu_done_q <= 1'b1;
            end else begin
                if (cpu_pend) cpu_wait <= 1'b1;
                if (!cpu_req) cpu_done_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (trigger || fetch_req_q) begin
                        state_q     <= StRamRd;
                        fetch_req_q <= 1'b0;
                    end else if (cpu_pend) begin
                        state_q <= StCpuAcc;
                    end
                end
                StRamRd: begin
                    rom_addr <= {tile_code, frow_q};
                    fcolor_q <= attr_rd[7 -: COLOR_W];
                    state_q  <= StRomAdr;
                end
                StRomAdr: state_q <= StRomLat;
                StRomLat: begin
                    pend_data_q  <= rom_data;
                    pend_color_q <= fcolor_q;
                    state_q      <= StIdle;
                end
                StCpuAcc: begin
                    if (cpu_rd) cpu_dout <= cpu_cs_code ? code_rd : attr_rd;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_layer_gen.sv
// Directed bench for tile_layer_gen: map writes, scrolled/flipped scan-out,
// CPU arbitration against fetches, and reset during a CPU access.
module tb_tile_layer_gen;
    logic        master_clk;
    logic        reset;
    logic        pix_ce;
    logic [8:0]  hpix;
    logic [7:0]  vpix;
    logic        flip;
    logic [8:0]  scroll_x;
    logic [7:0]  scroll_y;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_cs_code, cpu_cs_attr, cpu_rd, cpu_wr;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [12:0] rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  pixel_out;
    logic        transparent;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  pix_log [512];
    logic        trn_log [512];
    logic [12:0] rom_log [512];

    tile_layer_gen dut (
        .master_clk  (master_clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .hpix        (hpix),
        .vpix        (vpix),
        .flip        (flip),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_cs_code (cpu_cs_code),
        .cpu_cs_attr (cpu_cs_attr),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_dout    (cpu_dout),
        .cpu_wait    (cpu_wait),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_out   (pixel_out),
        .transparent (transparent)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    // Graphics ROM: tile 0x134 row 0 = 0x80/0x00, tile 0x205 row 0 = 0x0F/0xF0.
    always @(posedge master_clk) begin
        case (rom_addr)
            13'h09A0: rom_data <= 16'h0080;
            13'h1028: rom_data <= 16'hF00F;
            default:  rom_data <= 16'h0000;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_access(input logic wr, input logic cs_c, input logic cs_a,
                              input logic [10:0] addr, input logic [7:0] din,
                              output int waits);
        bit seen;
        seen  = 0;
        waits = 0;
        cpu_addr = addr; cpu_din = din; cpu_cs_code = cs_c; cpu_cs_attr = cs_a;
        cpu_wr = wr; cpu_rd = !wr;
        for (int i = 0; i < 12; i++) begin
            @(posedge master_clk); #1;
            if (cpu_wait) begin
                seen = 1;
                waits++;
            end else if (seen) begin
                break;
            end
        end
        if (!seen || cpu_wait) begin
            waits = -1;
            check("cpu_timeout", 32'd1, 32'd0);
        end
        cpu_wr = 0; cpu_rd = 0; cpu_cs_code = 0; cpu_cs_attr = 0;
        @(posedge master_clk); #1;
    endtask

    task automatic pix_step(input logic [8:0] h);
        hpix = h; pix_ce = 1;
        @(posedge master_clk); #1;
        pix_ce = 0;
        repeat (5) @(posedge master_clk);
        #1;
        pix_log[h] = pixel_out;
        trn_log[h] = transparent;
        rom_log[h] = rom_addr;
    endtask

    task automatic run_line();
        for (int i = 0; i < 48; i++) pix_step(9'((480 + i) % 512));
    endtask

    int w;
    int seen_w;
    bit seen;
    int blank_cells [4] = '{2, 61, 62, 63};

    initial begin
        reset = 1; pix_ce = 0; hpix = 0; vpix = 0; flip = 0; scroll_x = 0; scroll_y = 0;
        cpu_addr = 0; cpu_din = 0; cpu_cs_code = 0; cpu_cs_attr = 0; cpu_rd = 0; cpu_wr = 0;
        repeat (3) @(posedge master_clk);
        #1;
        check("rst_pixel", pixel_out, 8'h00);
        check("rst_transp", transparent, 1'b1);
        check("rst_wait", cpu_wait, 1'b0);
        check("rst_dout", cpu_dout, 8'h00);
        check("rst_rom_addr", rom_addr, 13'h0000);
        reset = 0;
        @(posedge master_clk); #1;

        cpu_access(1, 1, 0, 11'd0, 8'h34, w);
        cpu_access(1, 0, 1, 11'd0, 8'hC1, w);
        cpu_access(1, 1, 0, 11'd1, 8'h05, w);
        cpu_access(1, 0, 1, 11'd1, 8'h02, w);
        foreach (blank_cells[k]) begin
            cpu_access(1, 1, 0, 11'(blank_cells[k]), 8'h00, w);
            cpu_access(1, 0, 1, 11'(blank_cells[k]), 8'h00, w);
        end

        // V1: plain scan of row 0
        run_line();
        check("v1_rom_addr", rom_log[504], 13'h09A0);
        check("v1_pix0", pix_log[0], 8'hC1);
        check("v1_trn0", trn_log[0], 1'b0);
        check("v1_pix1", pix_log[1], 8'hC0);
        check("v1_trn1", trn_log[1], 1'b1);
        check("v1_pix8", pix_log[8], 8'h02);
        check("v1_pix12", pix_log[12], 8'h01);

        // V2: scroll_x = 3, column 511 wraps to column 0
        scroll_x = 9'd3;
        run_line();
        check("v2_rom_addr", rom_log[501], 13'h09A0);
        check("v2_col511", pix_log[508], 8'h00);
        check("v2_trn511", trn_log[508], 1'b1);
        check("v2_col0", pix_log[509], 8'hC1);
        check("v2_hpix0", pix_log[0], 8'hC0);
        check("v2_col8", pix_log[5], 8'h02);

        // V3: flipped; vpix 255 maps back to row 0
        scroll_x = 0; flip = 1; vpix = 8'd255;
        run_line();
        check("v3_rom_addr", rom_log[496], 13'h09A0);
        check("v3_col0", pix_log[511], 8'hC1);
        check("v3_col7", pix_log[504], 8'hC0);
        check("v3_trn7", trn_log[504], 1'b1);
        check("v3_col8", pix_log[503], 8'h02);
        check("v3_col15", pix_log[496], 8'h01);

        // V4: CPU write to cell 0 on the same clock as the fetch of cell 0
        flip = 0; vpix = 0;
        hpix = 9'd504; pix_ce = 1;
        cpu_addr = 0; cpu_din = 8'h77; cpu_cs_code = 1; cpu_wr = 1;
        seen = 0; seen_w = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge master_clk); #1;
            pix_ce = 0;
            if (cpu_wait) begin
                seen = 1;
                seen_w++;
            end else if (seen) begin
                break;
            end
        end
        cpu_wr = 0; cpu_cs_code = 0;
        @(posedge master_clk); #1;
        check("v4_wait_len", seen_w, 5);
        check("v4_fetch_old", rom_addr, 13'h09A0);
        cpu_access(0, 1, 0, 11'd0, 8'h00, w);
        check("v4_write_landed", cpu_dout, 8'h77);
        cpu_access(1, 1, 0, 11'd0, 8'h34, w);

        // V5: reads; both selects high read the code RAM
        cpu_access(0, 1, 1, 11'd0, 8'h00, w);
        check("v5_both_cs", cpu_dout, 8'h34);
        check("v5_wait_len", w, 1);
        cpu_access(0, 0, 1, 11'd0, 8'h00, w);
        check("v5_attr", cpu_dout, 8'hC1);
        cpu_access(0, 1, 0, 11'd1, 8'h00, w);
        check("v5_code1", cpu_dout, 8'h05);

        // V6: reset lands while the write sits in CPU_ACC
        cpu_addr = 0; cpu_din = 8'hEE; cpu_cs_code = 1; cpu_wr = 1;
        @(posedge master_clk); #1;
        check("v6_wait_hi", cpu_wait, 1'b1);
        reset = 1;
        @(posedge master_clk); #1;
        check("v6_wait", cpu_wait, 1'b0);
        check("v6_pixel", pixel_out, 8'h00);
        check("v6_transp", transparent, 1'b1);
        check("v6_dout", cpu_dout, 8'h00);
        check("v6_rom_addr", rom_addr, 13'h0000);
        cpu_wr = 0; cpu_cs_code = 0;
        repeat (2) @(posedge master_clk);
        #1;
        reset = 0;
        @(posedge master_clk); #1;
        cpu_access(0, 1, 0, 11'd0, 8'h00, w);
        check("v6_ram_kept", cpu_dout, 8'h34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
